// File: rtl/cg_ctrl_if.sv
// Per-channel handshake/activity bundle between a channel domain and cg_ctrl.
//   busy     : channel activity (from ungated logic)
//   force_on : per-channel gating inhibit
//   wake_req : wake request, level, held until wake_ack
//   wake_ack : clock is running, requester may proceed
//   clk_en   : enable to the channel clock-gate cell
//   gated_st : channel currently gated
interface cg_ctrl_if #(
    parameter int unsigned NUM_CH = 4
);
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] force_on;
    logic [NUM_CH-1:0] wake_req;
    logic [NUM_CH-1:0] wake_ack;
    logic [NUM_CH-1:0] clk_en;
    logic [NUM_CH-1:0] gated_st;

    // Channel side: drives activity and requests, receives gate control.
    modport master (
        output busy, force_on, wake_req,
        input  wake_ack, clk_en, gated_st
    );

    // Controller side.
    modport slave (
        input  busy, force_on, wake_req,
        output wake_ack, clk_en, gated_st
    );
endinterface

// File: rtl/cg_ctrl.sv
// Per-channel clock-gate enable sequencer for the DMA channel domains.
// Each channel gates its clock after a programmable run of idle cycles and
// ungates on activity, inhibit, or a wake_req/wake_ack handshake.
// Ports:
//   clk, rst_n   : ungated block clock, async active-low reset
//   cg_enable    : global gating permit (0 = no channel may gate)
//   idle_thresh  : idle cycles before gating (0 = gating disabled)
//   bus          : per-channel busy/force_on/wake_req in, wake_ack/clk_en/gated_st out
//   all_gated    : every channel gated (registered)
module cg_ctrl #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned IDLE_CNT_W = 8,
    parameter int unsigned WAKE_LAT   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cg_enable,
    input  logic [IDLE_CNT_W-1:0] idle_thresh,
    cg_ctrl_if.slave              bus,
    output logic                  all_gated
);

    localparam int unsigned WAKE_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_COUNT = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    state_t                state_q  [NUM_CH];
    state_t                state_d  [NUM_CH];
    logic [IDLE_CNT_W-1:0] cnt_q    [NUM_CH];
    logic [IDLE_CNT_W-1:0] cnt_d    [NUM_CH];
    logic [WAKE_CNT_W-1:0] wcnt_q   [NUM_CH];
    logic [WAKE_CNT_W-1:0] wcnt_d   [NUM_CH];
    logic [NUM_CH-1:0]     idle;
    logic [NUM_CH-1:0]     clk_en_d;
    logic [NUM_CH-1:0]     gated_d;
    logic [NUM_CH-1:0]     ack_d;
    logic                  thresh_on;

    // Next-state and next-output logic for every channel.
    always_comb begin
        thresh_on = (idle_thresh != '0);
        idle      = '0;
        clk_en_d  = '1;
        gated_d   = '0;
        ack_d     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            wcnt_d[i]  = wcnt_q[i];

            idle[i] = !bus.busy[i] && !bus.wake_req[i] && !bus.force_on[i]
                      && cg_enable && thresh_on;

            case (state_q[i])
                ST_RUN: begin
                    // Threshold is captured only here; later changes wait for re-entry.
                    if (idle[i]) begin
                        state_d[i] = ST_COUNT;
                        cnt_d[i]   = idle_thresh;
                    end
                end
                ST_COUNT: begin
                    if (!idle[i]) begin
                        state_d[i] = ST_RUN;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == IDLE_CNT_W'(1)) begin
                        state_d[i] = ST_GATED;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = IDLE_CNT_W'(cnt_q[i] - IDLE_CNT_W'(1));
                    end
                end
                ST_GATED: begin
                    if (bus.busy[i] || bus.wake_req[i] || bus.force_on[i] || !cg_enable) begin
                        state_d[i] = ST_WAKE;
                        wcnt_d[i]  = '0;
                    end
                end
                ST_WAKE: begin
                    // Runs to completion regardless of inputs so the clock settles.
                    wcnt_d[i] = WAKE_CNT_W'(wcnt_q[i] + WAKE_CNT_W'(1));
                    if (wcnt_d[i] == WAKE_CNT_W'(WAKE_LAT)) begin
                        state_d[i] = ST_RUN;
                    end
                end
                default: begin
                    state_d[i] = ST_RUN;
                end
            endcase

            clk_en_d[i] = (state_d[i] != ST_GATED);
            gated_d[i]  = (state_d[i] == ST_GATED);
            ack_d[i]    = (state_d[i] == ST_RUN) && bus.wake_req[i];
        end
    end

    // State, counters and registered outputs; reset forces all clocks on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_RUN;
                cnt_q[i]   <= '0;
                wcnt_q[i]  <= '0;
            end
            bus.clk_en   <= '1;
            bus.gated_st <= '0;
            bus.wake_ack <= '0;
            all_gated    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                wcnt_q[i]  <= wcnt_d[i];
            end
            bus.clk_en   <= clk_en_d;
            bus.gated_st <= gated_d;
            bus.wake_ack <= ack_d;
            all_gated    <= &gated_d;
        end
    end

endmodule

// File: tb/tb_cg_ctrl.sv
// Bench for cg_ctrl: per-cycle vector table with expected outputs queued at
// drive time and popped after the clock edge, plus an async reset sequence.
module tb_cg_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cg_enable;
    logic [7:0] idle_thresh;
    logic       all_gated;

    cg_ctrl_if #(.NUM_CH(4)) bus ();

    cg_ctrl #(
        .NUM_CH    (4),
        .IDLE_CNT_W(8),
        .WAKE_LAT  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cg_enable  (cg_enable),
        .idle_thresh(idle_thresh),
        .bus        (bus),
        .all_gated  (all_gated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cg;
        logic [7:0] thr;
        logic [3:0] busy;
        logic [3:0] fo;
        logic [3:0] wr;
        logic [3:0] e_clk;
        logic [3:0] e_gated;
        logic [3:0] e_ack;
        logic       e_all;
    } vec_t;

    typedef struct {
        int         id;
        logic [3:0] clk_en;
        logic [3:0] gated;
        logic [3:0] ack;
        logic       all;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(logic cg, logic [7:0] thr, logic [3:0] busy, logic [3:0] fo,
                                logic [3:0] wr, logic [3:0] e_clk, logic [3:0] e_gated,
                                logic [3:0] e_ack, logic e_all);
        vec_t v;
        v.cg = cg; v.thr = thr; v.busy = busy; v.fo = fo; v.wr = wr;
        v.e_clk = e_clk; v.e_gated = e_gated; v.e_ack = e_ack; v.e_all = e_all;
        return v;
    endfunction

    task automatic chk(input string name, input int id, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        chk("clk_en",    e.id, bus.clk_en,   e.clk_en);
        chk("gated_st",  e.id, bus.gated_st, e.gated);
        chk("wake_ack",  e.id, bus.wake_ack, e.ack);
        chk("all_gated", e.id, {3'b000, all_gated}, {3'b000, e.all});
    endtask

    // One clock: drive inputs mid-cycle, queue expectation, compare after the edge.
    task automatic apply(input vec_t v, input int id);
        exp_t e;
        @(negedge clk);
        cg_enable    = v.cg;
        idle_thresh  = v.thr;
        bus.busy     = v.busy;
        bus.force_on = v.fo;
        bus.wake_req = v.wr;
        e.id = id; e.clk_en = v.e_clk; e.gated = v.e_gated; e.ack = v.e_ack; e.all = v.e_all;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard step %0d: got empty queue expected entry", id);
        end else begin
            check_outputs(exp_q.pop_front());
        end
    endtask

    task automatic repeat_last(input int n, inout int id);
        vec_t v;
        v = vecs[vecs.size() - 1];
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   dummy;
        dummy = 0;

        // Baseline and ch0 gating with threshold 3.
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 0));
        vecs.push_back(mk(1, 3, 4'hE, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 0));
        repeat_last(2, dummy);
        vecs.push_back(mk(1, 3, 4'hE, 4'h0, 4'h0, 4'hE, 4'h1, 4'h0, 0));
        repeat_last(1, dummy);
        // Gate ch1.
        vecs.push_back(mk(1, 3, 4'hC, 4'h0, 4'h0, 4'hE, 4'h1, 4'h0, 0));
        repeat_last(2, dummy);
        vecs.push_back(mk(1, 3, 4'hC, 4'h0, 4'h0, 4'hC, 4'h3, 4'h0, 0));
        // Wake ch1 via handshake, then re-gate after 4 idle samples.
        vecs.push_back(mk(1, 3, 4'hC, 4'h0, 4'h2, 4'hE, 4'h1, 4'h0, 0));
        vecs.push_back(mk(1, 3, 4'hC, 4'h0, 4'h2, 4'hE, 4'h1, 4'h0, 0));
        vecs.push_back(mk(1, 3, 4'hC, 4'h0, 4'h2, 4'hE, 4'h1, 4'h2, 0));
        vecs.push_back(mk(1, 3, 4'hC, 4'h0, 4'h2, 4'hE, 4'h1, 4'h2, 0));
        vecs.push_back(mk(1, 3, 4'hC, 4'h0, 4'h0, 4'hE, 4'h1, 4'h0, 0));
        repeat_last(2, dummy);
        vecs.push_back(mk(1, 3, 4'hC, 4'h0, 4'h0, 4'hC, 4'h3, 4'h0, 0));
        // Wake request on a running channel.
        vecs.push_back(mk(1, 3, 4'hC, 4'h0, 4'h4, 4'hC, 4'h3, 4'h4, 0));
        vecs.push_back(mk(1, 3, 4'hC, 4'h0, 4'h0, 4'hC, 4'h3, 4'h0, 0));
        // ch3 countdown from 5 aborted at cnt==1, restarted, threshold change ignored.
        vecs.push_back(mk(1, 5, 4'h4, 4'h0, 4'h0, 4'hC, 4'h3, 4'h0, 0));
        repeat_last(4, dummy);
        vecs.push_back(mk(1, 5, 4'hC, 4'h0, 4'h0, 4'hC, 4'h3, 4'h0, 0));
        vecs.push_back(mk(1, 5, 4'h4, 4'h0, 4'h0, 4'hC, 4'h3, 4'h0, 0));
        vecs.push_back(mk(1, 1, 4'h4, 4'h0, 4'h0, 4'hC, 4'h3, 4'h0, 0));
        repeat_last(3, dummy);
        vecs.push_back(mk(1, 1, 4'h4, 4'h0, 4'h0, 4'h4, 4'hB, 4'h0, 0));
        // force_on wakes gated ch3.
        vecs.push_back(mk(1, 1, 4'h4, 4'h8, 4'h0, 4'hC, 4'h3, 4'h0, 0));
        repeat_last(3, dummy);
        // Gate everything.
        vecs.push_back(mk(1, 1, 4'h0, 4'h0, 4'h0, 4'hC, 4'h3, 4'h0, 0));
        vecs.push_back(mk(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1));
        repeat_last(1, dummy);
        // cg_enable low wakes all channels and holds them running.
        vecs.push_back(mk(0, 1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 0));
        repeat_last(3, dummy);
        vecs.push_back(mk(1, 1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 0));
        vecs.push_back(mk(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1));
        // wake_req and busy together on gated ch0: one wake sequence.
        vecs.push_back(mk(1, 1, 4'h1, 4'h0, 4'h1, 4'h1, 4'hE, 4'h0, 0));
        vecs.push_back(mk(1, 1, 4'h1, 4'h0, 4'h1, 4'h1, 4'hE, 4'h0, 0));
        vecs.push_back(mk(1, 1, 4'h1, 4'h0, 4'h1, 4'h1, 4'hE, 4'h1, 0));
        vecs.push_back(mk(1, 1, 4'h0, 4'h0, 4'h0, 4'h1, 4'hE, 4'h0, 0));
        vecs.push_back(mk(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1));
        // wake_req on ch1 dropped before ack: wake completes, no ack.
        vecs.push_back(mk(1, 1, 4'h0, 4'h0, 4'h2, 4'h2, 4'hD, 4'h0, 0));
        vecs.push_back(mk(1, 1, 4'h0, 4'h0, 4'h0, 4'h2, 4'hD, 4'h0, 0));
        repeat_last(2, dummy);
        vecs.push_back(mk(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1));

        // Reset for 3 cycles with quiet inputs.
        rst_n        = 1'b0;
        cg_enable    = 1'b1;
        idle_thresh  = 8'd0;
        bus.busy     = 4'h0;
        bus.force_on = 4'h0;
        bus.wake_req = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        e.id = -1; e.clk_en = 4'hF; e.gated = 4'h0; e.ack = 4'h0; e.all = 1'b0;
        check_outputs(e);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);

        // Async reset mid-cycle while every channel is gated.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        e.id = 1000; e.clk_en = 4'hF; e.gated = 4'h0; e.ack = 4'h0; e.all = 1'b0;
        check_outputs(e);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(1, 0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 0), 1001);
        apply(mk(1, 0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 0), 1002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cg_ctrl.md
Name: cg_ctrl

Overview:
- Per-channel clock-gate enable sequencer for the DMA.
- Drives the clk_en input of one clock-gate cell per channel domain.
- Gates a domain after a programmable run of idle cycles.
- Ungates on activity, or on a req/ack wake handshake that guarantees the clock is stable before the requester proceeds.

Parameters:
- NUM_CH, 4: number of independent gated channel domains.
- IDLE_CNT_W, 8: width of the idle-threshold counter.
- WAKE_LAT, 2: cycles clk_en is held high in WAKE before returning to RUN (range 1..15).

Ports:
- clk  input  1  block clock (ungated).
- rst_n  input  1  reset, asynchronous, active-low.
- cg_enable  input  1  global gating permit; 0 = no channel may gate.
- idle_thresh  input  IDLE_CNT_W  idle cycles before gating; 0 = gating disabled for all channels.
- force_on  input  NUM_CH  per-channel gating inhibit.
- busy  input  NUM_CH  per-channel activity, from ungated logic.
- wake_req  input  NUM_CH  per-channel wake request; level, held until wake_ack.
- wake_ack  output  NUM_CH  wake acknowledge; clock is running.
- clk_en  output  NUM_CH  registered enable to the channel clock gate.
- gated_st  output  NUM_CH  1 while the channel is in GATED.
- all_gated  output  1  registered AND of the gated_st bits.

Behaviour:
- Channels are fully independent; each has a 2-bit FSM (RUN, COUNT, GATED, WAKE), an IDLE_CNT_W idle counter and a 4-bit wake counter.
- Definitions: idle = !busy & !wake_req & !force_on & cg_enable & (idle_thresh != 0). All outputs are registered.
- Reset, asynchronous and immediate: state RUN, clk_en=1, wake_ack=0, gated_st=0, all_gated=0, counters 0. Reset asserted mid-operation (any state) forces these values at once; clocks are never left gated under reset.
- RUN: clk_en=1. If idle → COUNT and load cnt=idle_thresh; otherwise stay in RUN.
- COUNT: clk_en=1. If !idle → RUN and discard cnt. If idle and cnt==1 → GATED; else cnt decrements.
- Gating timing: clk_en falls after idle_thresh+1 consecutive idle samples.
- idle_thresh is sampled only on the RUN→COUNT transition; changing it during COUNT has no effect until the next entry.
- GATED: clk_en=0, gated_st=1. Any of busy, wake_req, force_on, !cg_enable → WAKE; clk_en=1 and gated_st=0 in the cycle after the sample, and the wake counter clears.
- WAKE: clk_en=1. The wake counter increments; when it reaches WAKE_LAT → RUN. WAKE always completes; no return to GATED or COUNT mid-wake.
- wake_ack is registered as (next_state==RUN) & wake_req. It stays high while wake_req is high in RUN and drops the cycle after wake_req is sampled low.
- wake_req held in RUN blocks gating, because it makes the channel non-idle.
- Simultaneous events:
  - COUNT with cnt==1 and busy rising in the same cycle → RUN, no gating.
  - GATED with wake_req and busy both rising → single WAKE sequence.
  - wake_req dropped before ack → no ack is issued; the FSM still completes WAKE→RUN.
- all_gated = AND of the next-state gated_st bits, registered.

Test Plan:
- Reset / baseline: rst_n low for 3 cycles, busy=0, idle_thresh=0 → clk_en=4'hF, gated_st=0, wake_ack=0, all_gated=0, held indefinitely with cg_enable=1.
- Idle gating: idle_thresh=3, cg_enable=1, ch0 busy falls before edge e0 → clk_en[0] low after edge e3, gated_st[0]=1, other channels unchanged while they stay busy.
- Wake from gated: WAKE_LAT=2, ch1 GATED, wake_req[1] rises before e0 → clk_en[1]=1 after e0, wake_ack[1]=1 after e2; wake_req drops → ack low next cycle; then re-gating after 4 idle samples.
- Wake in RUN: ch2 in RUN, wake_req[2] rises → wake_ack[2] high one cycle later, clk_en never drops.
- Aborted countdown and inhibits:
  - idle_thresh=5, busy[3] pulses for 1 cycle at countdown cnt==1 → no gating, countdown restarts.
  - force_on[3]=1 or cg_enable=0 while GATED → WAKE then RUN.
- Reset mid-operation: all channels GATED (all_gated=1), async rst_n pulse mid-cycle → clk_en=4'hF and all_gated=0 immediately, without waiting for a clock edge.
